bigmac_sched: RTL and testbench

Two-thread scheduler for the shared decaying multiply-accumulate datapath. Two independent ready/valid requester streams share one ×27/32 decay-and-add unit. The block keeps a separate accumulator context per thread and arbitrates round-robin between the streams. Each result leaves through a single-entry elastic output register tagged with its thread. It sits between two producer streams and one downstream consumer.

---
 rtl/bigmac_sched.sv | 99 +++++++++
 tb/tb_bigmac_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bigmac_sched.sv
// Two-thread round-robin scheduler in front of a shared x27/32 decay-and-add unit.
// Define BIGMAC_SCHED_STRICT_PRIO_EN for fixed priority (thread 0 always wins).
module bigmac_sched #(
  parameter int width_p = 10
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [width_p-1:0]     data0_i,
  input  logic                   valid0_i,
  output logic                   ready0_o,
  input  logic [width_p-1:0]     data1_i,
  input  logic                   valid1_i,
  output logic                   ready1_o,
  output logic                   valid_o,
  output logic [2*width_p-1:0]   data_o,
  output logic                   thread_o,
  input  logic                   ready_i
);

  localparam int acc_w  = 2 * width_p;
  localparam int prod_w = acc_w + 5;

  logic                   space;
  logic [1:0]             valid_in;
  logic [1:0]             grant;
  logic [1:0][width_p-1:0] sample;
  logic [1:0][acc_w-1:0]  acc_next;

  logic                   valid_reg;
  logic [acc_w-1:0]       data_reg;
  logic                   thread_reg;

  assign valid_in = {valid1_i, valid0_i};
  assign sample   = {data1_i, data0_i};

  // Reset is folded in so neither requester sees ready while the block is held.
  assign space = (~valid_reg | ready_i) & ~reset_i;

`ifdef BIGMAC_SCHED_STRICT_PRIO_EN
  assign grant[0] = space & valid_in[0];
  assign grant[1] = space & valid_in[1] & ~valid_in[0];
`else
  logic prio_reg;

  assign grant[0] = space & valid_in[0] & (~prio_reg | ~valid_in[1]);
  assign grant[1] = space & valid_in[1] & ( prio_reg | ~valid_in[0]);

  // The thread that just won yields preference to the other one.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prio_reg <= 1'b0;
    end else if (|grant) begin
      prio_reg <= grant[0];
    end
  end
`endif

  assign ready0_o = grant[0];
  assign ready1_o = grant[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ctx
      logic [acc_w-1:0]  acc_reg;
      logic [prod_w-1:0] prod;

      // Product keeps the 5 guard bits so the >>5 is exact before truncation.
      assign prod         = prod_w'(acc_reg) * prod_w'(27);
      assign acc_next[gi] = prod[prod_w-1:5] + acc_w'(sample[gi]);

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          acc_reg <= '0;
        end else if (grant[gi]) begin
          acc_reg <= acc_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      thread_reg <= 1'b0;
    end else if (|grant) begin
      valid_reg  <= 1'b1;
      data_reg   <= grant[1] ? acc_next[1] : acc_next[0];
      thread_reg <= grant[1];
    end else if (ready_i) begin
      valid_reg  <= 1'b0;
    end
  end

  assign valid_o  = valid_reg;
  assign data_o   = data_reg;
  assign thread_o = thread_reg;

endmodule

// File: tb/tb_bigmac_sched.sv
// Randomized scoreboard bench for bigmac_sched against a plain-arithmetic reference model.
// Honours BIGMAC_SCHED_STRICT_PRIO_EN the same way the design does.
module tb_bigmac_sched;
  localparam int W  = 10;
  localparam int AW = 2 * W;

  typedef struct {
    int              thr;
    longint unsigned val;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [W-1:0]  data0, data1;
  logic          valid0, valid1, ready0, ready1;
  logic          valid_o, thread_o, ready_i;
  logic [AW-1:0] data_o;

  int total = 0;
  int bad   = 0;

  longint unsigned m_acc [2];
  int              m_prio;
  bit              m_valid;
  exp_t            sb [$];

  bit              hold_prev;
  logic [AW-1:0]   hold_data;
  logic            hold_thr;

  always #5 clk = ~clk;

  bigmac_sched #(.width_p(W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .data0_i(data0), .valid0_i(valid0), .ready0_o(ready0),
    .data1_i(data1), .valid1_i(valid1), .ready1_o(ready1),
    .valid_o(valid_o), .data_o(data_o), .thread_o(thread_o), .ready_i(ready_i)
  );

  function automatic longint unsigned ref_step(longint unsigned acc, longint unsigned d);
    longint unsigned mask;
    mask = (64'd1 << AW) - 1;
    return (((acc * 27) >> 5) + d) & mask;
  endfunction

  // Reference model: decides who is served, predicts handshakes, queues results.
  always @(negedge clk) begin : model_p
    int   pick;
    int   pref;
    bit   req [2];
    exp_t e;
    total++;
    if (valid_o !== m_valid) begin
      bad++;
      $display("FAIL valid_o got=%0b want=%0b", valid_o, m_valid);
    end
`ifdef BIGMAC_SCHED_STRICT_PRIO_EN
    pref = 0;
`else
    pref = m_prio;
`endif
    req[0] = valid0;
    req[1] = valid1;
    pick = -1;
    if (!reset_i && (!m_valid || ready_i)) begin
      if (req[pref]) pick = pref;
      else if (req[1-pref]) pick = 1 - pref;
    end
    total++;
    if (ready0 !== (pick == 0) || ready1 !== (pick == 1)) begin
      bad++;
      $display("FAIL ready got=%0b%0b want=%0b%0b", ready1, ready0, pick == 1, pick == 0);
    end
    if (reset_i) begin
      m_acc[0] = 0;
      m_acc[1] = 0;
      m_prio   = 0;
      m_valid  = 0;
      sb.delete();
    end else if (pick >= 0) begin
      m_acc[pick] = ref_step(m_acc[pick], (pick == 1) ? longint'(data1) : longint'(data0));
      e.thr = pick;
      e.val = m_acc[pick];
      sb.push_back(e);
      m_prio  = (pick == 0) ? 1 : 0;
      m_valid = 1;
    end else if (ready_i) begin
      m_valid = 0;
    end
  end

  // Monitor: pops on every consumed result and checks stability under backpressure.
  always @(negedge clk) begin : monitor_p
    exp_t e;
    if (reset_i) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        total++;
        if (!valid_o || data_o !== hold_data || thread_o !== hold_thr) begin
          bad++;
          $display("FAIL hold got=%0b/%0d/%0d want=1/%0d/%0d",
                   valid_o, thread_o, data_o, hold_thr, hold_data);
        end
      end
      if (valid_o && ready_i) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result got=%0d/%0d want=none", thread_o, data_o);
        end else begin
          e = sb.pop_front();
          if (thread_o !== e.thr[0] || longint'(data_o) != e.val) begin
            bad++;
            $display("FAIL result got=%0d/%0d want=%0d/%0d", thread_o, data_o, e.thr, e.val);
          end else begin
            $display("txn thread=%0d data=%0d ok", thread_o, data_o);
          end
        end
      end
      hold_prev = valid_o && !ready_i;
      hold_data = data_o;
      hold_thr  = thread_o;
    end
  end

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid0  = 1'b0;
    valid1  = 1'b0;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Single isolated sample on one thread, checked against a known constant.
  task automatic send(input int t, input int v, input int want);
    ready_i = 1'b1;
    if (t == 0) begin valid0 = 1'b1; data0 = W'(v); end
    else        begin valid1 = 1'b1; data1 = W'(v); end
    step();
    valid0 = 1'b0;
    valid1 = 1'b0;
    @(negedge clk);
    check("send_valid", valid_o, 1);
    check("send_data", data_o, want);
    check("send_thread", thread_o, t);
    step();
  endtask

  initial begin
    int            alt_d [4];
    int            alt_t [4];
    int            cnt;
    logic [AW-1:0] snap_d;
    logic          snap_t;
`ifdef BIGMAC_SCHED_STRICT_PRIO_EN
    alt_d = '{10, 18, 25, 31};
    alt_t = '{0, 0, 0, 0};
`else
    alt_d = '{10, 10, 18, 18};
    alt_t = '{0, 1, 0, 1};
`endif
    reset_i = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0;
    data0 = '0; data1 = '0;
    ready_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("reset_valid", valid_o, 0);
    check("reset_data", data_o, 0);
    check("reset_thread", thread_o, 0);
    step();
    reset_i = 1'b0;

    send(0, 32, 32);
    send(0, 32, 59);

    do_reset();
    send(1, 100, 100);
    send(1, 0, 84);
    send(0, 1, 1);

    // Both requesters continuously active.
    do_reset();
    valid0 = 1'b1; valid1 = 1'b1;
    data0 = 10; data1 = 10;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("alt_data", data_o, alt_d[i]);
      check("alt_thread", thread_o, alt_t[i]);
    end

    // Backpressure with both requesters still asking.
    step();
    ready_i = 1'b0;
    @(negedge clk);
    snap_d = data_o;
    snap_t = thread_o;
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("bp_data", data_o, snap_d);
      check("bp_thread", thread_o, snap_t);
      check("bp_ready0", ready0, 0);
      check("bp_ready1", ready1, 0);
    end
    step();
    ready_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      if (valid_o) cnt++;
    end
    check("resume_rate", cnt, 4);
    step();
    valid0 = 1'b0; valid1 = 1'b0;

    // Saturating run of maximum samples on thread 0.
    do_reset();
    valid0 = 1'b1; data0 = 1023;
    repeat (300) step();
    valid0 = 1'b0;
    step();
    step();

    // Reset landing while results are streaming.
    do_reset();
    valid0 = 1'b1; valid1 = 1'b1;
    data0 = 7; data1 = 9;
    step();
    step();
    reset_i = 1'b1;
    step();
    check("midrst_valid", valid_o, 0);
    check("midrst_data", data_o, 0);
    valid0 = 1'b0; valid1 = 1'b0;
    reset_i = 1'b0;
    send(1, 5, 5);
    send(0, 5, 5);

    // Randomized traffic, including withdrawn valids and occasional resets.
    repeat (3000) begin
      step();
      reset_i = ($urandom_range(0, 299) == 0);
      valid0  = ($urandom_range(0, 2) != 0);
      valid1  = ($urandom_range(0, 2) != 0);
      data0   = ($urandom_range(0, 3) == 0) ? W'(1023) : W'($urandom_range(0, 1023));
      data1   = ($urandom_range(0, 3) == 0) ? W'(1023) : W'($urandom_range(0, 1023));
      ready_i = ($urandom_range(0, 3) != 0);
    end

    step();
    reset_i = 1'b0;
    valid0 = 1'b0; valid1 = 1'b0;
    ready_i = 1'b1;
    repeat (4) step();
    @(negedge clk);
    check("drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
